// File: rtl/halut_decoder_gather.sv
// Result gatherer for a bank of halut decoder sub-units. It accepts one result per cycle in ordered
// or round-robin order and queues each result, tagged with its M address, in a small output FIFO.
module halut_decoder_gather #(
   parameter int DecoderUnits = 16,
   parameter int ResultWidth  = 32,
   parameter int FifoDepth    = 4,
   parameter int OrderedMode  = 1,
   parameter int DecAddrWidth = $clog2(DecoderUnits)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  enable_i,
   input  logic                                  flush_i,
   input  logic [DecoderUnits*ResultWidth-1:0]   unit_result_i,
   input  logic [DecoderUnits-1:0]               unit_valid_i,
   output logic [DecoderUnits-1:0]               unit_ready_o,
   output logic [ResultWidth-1:0]                result_o,
   output logic [DecAddrWidth-1:0]               m_addr_o,
   output logic                                  valid_o,
   input  logic                                  ready_i,
   output logic [$clog2(FifoDepth+1)-1:0]        count_o,
   output logic                                  round_done_o
);

   localparam int CntWidth = $clog2(FifoDepth + 1);
   localparam int IdxWidth = $clog2(FifoDepth);
   localparam logic [DecAddrWidth-1:0] LastUnit  = DecAddrWidth'(DecoderUnits - 1);
   localparam logic [DecAddrWidth:0]   UnitCount = (DecAddrWidth + 1)'(DecoderUnits);
   localparam logic [IdxWidth-1:0]     LastSlot  = IdxWidth'(FifoDepth - 1);
   localparam logic [CntWidth-1:0]     FullCount = CntWidth'(FifoDepth);

   logic [ResultWidth-1:0]  unit_result [DecoderUnits];
   logic [DecAddrWidth-1:0] ptr_q;
   logic [CntWidth-1:0]     count_q;
   logic [IdxWidth-1:0]     rd_idx_q;
   logic [IdxWidth-1:0]     wr_idx_q;
   logic                    round_done_q;
   logic [ResultWidth-1:0]  mem_data [FifoDepth];
   logic [DecAddrWidth-1:0] mem_addr [FifoDepth];

   logic                    pop;
   logic                    space;
   logic                    accept_en;
   logic                    grant_valid;
   logic [DecAddrWidth-1:0] grant_idx;
   logic [DecAddrWidth:0]   cand;

   for (genvar x = 0; x < DecoderUnits; x++) begin : g_unpack
      assign unit_result[x] = unit_result_i[x*ResultWidth +: ResultWidth];
   end

   assign valid_o   = (count_q != '0);
   assign pop       = valid_o & ready_i;
   assign space     = (count_q != FullCount) | pop;
   assign accept_en = ~rst_i & enable_i & ~flush_i & space;

   // Ordered mode waits on the pointer; round-robin scans cyclically from it with explicit wrap.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = ptr_q;
      cand        = '0;
      if (accept_en) begin
         if (OrderedMode != 0) begin
            grant_valid = unit_valid_i[ptr_q];
         end else begin
            for (int k = 0; k < DecoderUnits; k++) begin
               cand = {1'b0, ptr_q} + (DecAddrWidth + 1)'(k);
               if (cand >= UnitCount) cand = cand - UnitCount;
               if (!grant_valid && unit_valid_i[cand[DecAddrWidth-1:0]]) begin
                  grant_valid = 1'b1;
                  grant_idx   = cand[DecAddrWidth-1:0];
               end
            end
         end
      end
   end

   // NOTE: every output of an always_comb block gets a default first, so no latch is inferred.
   always_comb begin
      unit_ready_o = '0;
      if (grant_valid) unit_ready_o[grant_idx] = 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q        <= '0;
         count_q      <= '0;
         rd_idx_q     <= '0;
         wr_idx_q     <= '0;
         round_done_q <= 1'b0;
      end else begin
         round_done_q <= (OrderedMode != 0) && grant_valid && (grant_idx == LastUnit);
         if (!enable_i || flush_i) begin
            ptr_q <= '0;
         end else if (grant_valid) begin
            ptr_q <= (grant_idx == LastUnit) ? '0 : grant_idx + DecAddrWidth'(1);
         end
         if (flush_i) begin
            count_q  <= '0;
            rd_idx_q <= '0;
            wr_idx_q <= '0;
         end else begin
            if (grant_valid) wr_idx_q <= (wr_idx_q == LastSlot) ? '0 : wr_idx_q + IdxWidth'(1);
            if (pop)         rd_idx_q <= (rd_idx_q == LastSlot) ? '0 : rd_idx_q + IdxWidth'(1);
            case ({grant_valid, pop})
               2'b10:   count_q <= count_q + CntWidth'(1);
               2'b01:   count_q <= count_q - CntWidth'(1);
               default: count_q <= count_q;
            endcase
         end
      end
   end

   // NOTE: the storage array is not reset; its contents only reach the outputs while valid_o is high.
   always_ff @(posedge clk_i) begin
      if (grant_valid) begin
         mem_data[wr_idx_q] <= unit_result[grant_idx];
         mem_addr[wr_idx_q] <= grant_idx;
      end
   end

   assign result_o     = valid_o ? mem_data[rd_idx_q] : '0;
   assign m_addr_o     = valid_o ? mem_addr[rd_idx_q] : '0;
   assign count_o      = count_q;
   assign round_done_o = round_done_q;

endmodule

// File: doc/halut_decoder_gather.md
# halut_decoder_gather

Result gatherer placed behind a bank of `DecoderUnits` halut decoder sub-units. It collects one FP32 result per unit in strict M-address order or round-robin order, whichever mode is configured. It buffers the results in a small FIFO and presents them on a ready/valid output stream tagged with the originating M address. Unlike the earlier gatherer, it holds its position when a unit is not yet valid, back-pressures the units, tolerates output stalls, and supports any unit count, including non-power-of-two counts.

## Interface
- `DecoderUnits`, 16, number of decoder sub-units served; ≥ 2.
- `ResultWidth`, 32, result word width (FP32 by default).
- `FifoDepth`, 4, output FIFO entries; ≥ 2.
- `OrderedMode`, 1, 1 = strict ascending M order; 0 = round-robin over valid units.
- `DecAddrWidth`, `$clog2(DecoderUnits)`, M address width.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `enable_i`  in  1  gathering enabled; low parks the pointer at 0.
- `flush_i`  in  1  single-cycle request: empty the FIFO and reset the pointer.
- `unit_result_i`  in  DecoderUnits*ResultWidth  flattened results; unit x occupies bits [x*ResultWidth +: ResultWidth].
- `unit_valid_i`  in  DecoderUnits  result of unit x is available.
- `unit_ready_o`  out  DecoderUnits  one-hot (or zero) accept strobe to the units.
- `result_o`  out  ResultWidth  FIFO head result.
- `m_addr_o`  out  DecAddrWidth  FIFO head M address.
- `valid_o`  out  1  FIFO non-empty.
- `ready_i`  in  1  downstream accepts the head.
- `count_o`  out  $clog2(FifoDepth+1)  FIFO fill level.
- `round_done_o`  out  1  one-cycle pulse on accepting unit DecoderUnits-1 in ordered mode.

## Operation
- **Pointer `ptr`** ranges over 0..DecoderUnits-1. It wraps explicitly from DecoderUnits-1 to 0; it does not rely on power-of-two overflow.
- **Pop:** `pop = valid_o & ready_i`.
- **Space:** `space = (count != FifoDepth) | pop`. Pushing into a full FIFO in the same cycle as a pop is allowed.
- **Accept enable:** an accept is allowed only when `enable_i & ~flush_i & space`. At most one accept per cycle.
- **Ordered mode:**
  - Candidate is `ptr`.
  - Accept iff `unit_valid_i[ptr]`.
  - On accept, `ptr` increments with wrap.
  - If the candidate is not valid, `ptr` holds: wait, do not restart. Other valid units are ignored.
  - `round_done_o` pulses on accepting unit DecoderUnits-1.
- **Round-robin mode:**
  - Grant goes to the first valid unit searching cyclically from `ptr`.
  - On grant g, `ptr` becomes g+1 with wrap.
  - `round_done_o` stays 0.
- **Accept actions:** `unit_ready_o[g]=1` (combinational from inputs and state), and the entry {g, `unit_result_i[g]`} is pushed.
- **`enable_i` low:** no accepts and `ptr` goes to 0 next cycle. The FIFO keeps draining.
- **`flush_i`:** next cycle the FIFO is empty and `ptr`=0. A pop in the flush cycle is still a valid transfer. A flush suppresses any accept in the same cycle.
- **Empty FIFO:** `result_o`=0 and `m_addr_o`=0.

## Timing
- **Reset:** `ptr`=0, FIFO empty, `valid_o`=0, `result_o`=0, `m_addr_o`=0, `count_o`=0, `round_done_o`=0. `unit_ready_o`=0 while `rst_i` is high.
- **Latency:** an accept at edge N makes the entry visible at the head from cycle N+1 if the FIFO was empty; there is no fall-through.
- **Throughput:** 1 result per cycle sustained when `ready_i` is held high.
- **Output contract:** `result_o` and `m_addr_o` are stable while `valid_o & ~ready_i`.
- **`count_o`:** increments on push-only, decrements on pop-only, and is unchanged on push+pop.
- **`round_done_o`:** registered; asserted the cycle after the final accept.
- **Reset mid-operation:** all state is cleared on the next edge; in-flight results are discarded.

## Test plan
- **Ordered sweep:** DecoderUnits=5, OrderedMode=1, all `unit_valid_i` high, `ready_i` high. Expect 5 consecutive beats with `m_addr_o` 0,1,2,3,4 and `round_done_o` one pulse after the unit-4 accept, then the sequence repeats from 0 (non-power-of-two wrap).
- **Ordered wait:** unit 2 invalid for 3 cycles while 3 and 4 are valid. Expect `ptr` to hold at 2 with no accepts. When unit 2 is raised, expect the beats 2,3,4 in order.
- **Backpressure:** FifoDepth=4, `ready_i` low. Expect exactly 4 accepts and `count_o`=4, then `unit_ready_o`=0. Raising `ready_i` for one cycle gives one pop plus one accept, with `count_o` staying at 4.
- **Round-robin:** OrderedMode=0, only units 1 and 3 valid, `ptr`=2. Expect a grant to 3 then 1, alternating.
- **Flush and reset:**
  - `flush_i` with 3 entries queued and `unit_valid_i` high: `unit_ready_o`=0 that cycle and `count_o`=0 next cycle.
  - `rst_i` mid-stream: all outputs zero on the next edge.
